// File: rtl/secded72_decoder.sv
// Registered (72,64) Hsiao SECDED decoder: one codeword in, one corrected word out per cycle.
// Optional saturating error counters are compiled in with ECC_STATS_EN.
module secded72_decoder
`ifdef ECC_STATS_EN
#(
  parameter int unsigned CNT_W = 16
)
`endif
(
  input  logic        clk,
  input  logic        rst,
  input  logic [71:0] IN,
  output logic [71:0] OUT,
  output logic [7:0]  SYN,
  output logic        ERR,
  output logic        SGL,
  output logic        DBL
`ifdef ECC_STATS_EN
  ,
  output logic [CNT_W-1:0] SGL_CNT,
  output logic [CNT_W-1:0] DBL_CNT
`endif
);

  localparam int unsigned N_BITS  = 72;
  localparam int unsigned N_DATA  = 64;
  localparam int unsigned N_W3    = 56;

  // H-matrix columns: weight-3 bytes ascending, then the 8 smallest weight-5, then unit check columns.
  function automatic logic [N_BITS-1:0][7:0] h_table();
    logic [N_BITS-1:0][7:0] t;
    int unsigned n3;
    int unsigned n5;
    t  = '0;
    n3 = 0;
    n5 = 0;
    for (int unsigned v = 1; v < 256; v++) begin
      if ($countones(8'(v)) == 3 && n3 < N_W3) begin
        t[n3] = 8'(v);
        n3++;
      end else if ($countones(8'(v)) == 5 && n5 < (N_DATA - N_W3)) begin
        t[N_W3 + n5] = 8'(v);
        n5++;
      end
    end
    for (int unsigned j = 0; j < 8; j++) begin
      t[N_DATA + j] = 8'(1) << j;
    end
    return t;
  endfunction

  localparam logic [N_BITS-1:0][7:0] H = h_table();

  logic [7:0]        syn_c;
  logic [N_BITS-1:0] hit_c;
  logic [N_BITS-1:0] out_c;
  logic              sgl_c;
  logic              dbl_c;

  // Syndrome, column match and correction; columns are all odd weight and non-zero.
  always_comb begin
    syn_c = '0;
    hit_c = '0;
    for (int k = 0; k < N_BITS; k++) begin
      if (IN[k]) begin
        syn_c = syn_c ^ H[k];
      end
    end
    for (int k = 0; k < N_BITS; k++) begin
      hit_c[k] = (syn_c == H[k]);
    end
    sgl_c = |hit_c;
    dbl_c = (syn_c != 8'h00) && !sgl_c;
    out_c = IN ^ hit_c;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      OUT <= '0;
      SYN <= '0;
      ERR <= 1'b0;
      SGL <= 1'b0;
      DBL <= 1'b0;
    end else begin
      OUT <= out_c;
      SYN <= syn_c;
      ERR <= sgl_c | dbl_c;
      SGL <= sgl_c;
      DBL <= dbl_c;
    end
  end

`ifdef ECC_STATS_EN
  // Saturating counters of registered flags; they lag the flag by one edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      SGL_CNT <= '0;
      DBL_CNT <= '0;
    end else begin
      if (SGL && (SGL_CNT != '1)) begin
        SGL_CNT <= SGL_CNT + CNT_W'(1);
      end
      if (DBL && (DBL_CNT != '1)) begin
        DBL_CNT <= DBL_CNT + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_secded72_decoder.sv
// Self-checking bench for secded72_decoder: directed plan cases plus random words against a reference model.
`timescale 1ns/1ps
module tb_secded72_decoder;

  logic        clk;
  logic        rst;
  logic [71:0] IN;
  logic [71:0] OUT;
  logic [7:0]  SYN;
  logic        ERR;
  logic        SGL;
  logic        DBL;
`ifdef ECC_STATS_EN
  logic [15:0] SGL_CNT;
  logic [15:0] DBL_CNT;
  int          exp_sgl_cnt;
  int          exp_dbl_cnt;
`endif

  int cmp_count;
  int mism_count;
  logic [7:0] cols [72];

  secded72_decoder dut (
    .clk (clk),
    .rst (rst),
    .IN  (IN),
    .OUT (OUT),
    .SYN (SYN),
    .ERR (ERR),
    .SGL (SGL),
    .DBL (DBL)
`ifdef ECC_STATS_EN
    ,
    .SGL_CNT (SGL_CNT),
    .DBL_CNT (DBL_CNT)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Column table built directly from the weight rules using queues.
  task automatic build_cols();
    logic [7:0] w3 [$];
    logic [7:0] w5 [$];
    for (int v = 1; v < 256; v++) begin
      if ($countones(8'(v)) == 3) w3.push_back(8'(v));
      if ($countones(8'(v)) == 5) w5.push_back(8'(v));
    end
    for (int k = 0; k < 56; k++) cols[k] = w3[k];
    for (int k = 0; k < 8; k++)  cols[56 + k] = w5[k];
    for (int j = 0; j < 8; j++)  cols[64 + j] = 8'(1) << j;
  endtask

  function automatic logic [7:0] syndrome_of(input logic [71:0] w);
    logic [7:0] s = '0;
    for (int k = 0; k < 72; k++) if (w[k]) s ^= cols[k];
    return s;
  endfunction

  function automatic void ref_dec(input logic [71:0] w, output logic [71:0] o,
                                  output logic [7:0] s, output logic sg, output logic db);
    int idx = -1;
    s  = syndrome_of(w);
    o  = w;
    sg = 1'b0;
    db = 1'b0;
    for (int k = 0; k < 72; k++) if (s != 8'h00 && cols[k] == s) idx = k;
    if (idx >= 0) begin
      sg = 1'b1;
      o[idx] = ~o[idx];
    end else if (s != 8'h00) begin
      db = 1'b1;
    end
  endfunction

  function automatic logic [71:0] rnd72();
    return {8'($urandom), 32'($urandom), 32'($urandom)};
  endfunction

  // Valid codeword: check bits chosen to cancel the data syndrome.
  function automatic logic [71:0] valid_word(input logic [63:0] d);
    logic [71:0] w = {8'h00, d};
    return {syndrome_of(w), d};
  endfunction

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    cmp_count++;
    assert (obs === exp) else begin
      mism_count++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [71:0] eo, input logic [7:0] es,
                           input logic esg, input logic edb);
    chk({tag, ".out"}, OUT, eo);
    chk({tag, ".syn"}, 72'(SYN), 72'(es));
    chk({tag, ".err"}, 72'(ERR), 72'(esg | edb));
    chk({tag, ".sgl"}, 72'(SGL), 72'(esg));
    chk({tag, ".dbl"}, 72'(DBL), 72'(edb));
`ifdef ECC_STATS_EN
    chk({tag, ".sgl_cnt"}, 72'(SGL_CNT), 72'(exp_sgl_cnt));
    chk({tag, ".dbl_cnt"}, 72'(DBL_CNT), 72'(exp_dbl_cnt));
    if (esg && exp_sgl_cnt < 65535) exp_sgl_cnt++;
    if (edb && exp_dbl_cnt < 65535) exp_dbl_cnt++;
`endif
  endtask

  // One word per cycle: drive on the falling edge, check 1 ns after the next rising edge.
  task automatic step_exp(input string tag, input logic [71:0] w, input logic [71:0] eo,
                          input logic [7:0] es, input logic esg, input logic edb);
    @(negedge clk);
    IN = w;
    @(posedge clk);
    #1;
    check_all(tag, eo, es, esg, edb);
  endtask

  task automatic step_ref(input string tag, input logic [71:0] w);
    logic [71:0] eo;
    logic [7:0]  es;
    logic        esg;
    logic        edb;
    ref_dec(w, eo, es, esg, edb);
    step_exp(tag, w, eo, es, esg, edb);
  endtask

  logic [71:0] base;
  logic [71:0] w;

  initial begin
    cmp_count  = 0;
    mism_count = 0;
`ifdef ECC_STATS_EN
    exp_sgl_cnt = 0;
    exp_dbl_cnt = 0;
`endif
    build_cols();

    rst = 1'b1;
    IN  = rnd72();
    repeat (3) @(posedge clk);
    #1;
    check_all("reset_hold", 72'h0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_all("reset_release", 72'h0, 8'h00, 1'b0, 1'b0);

    step_exp("zero",      72'h0, 72'h0, 8'h00, 1'b0, 1'b0);
    step_exp("bit0",      72'h1, 72'h0, 8'h07, 1'b1, 1'b0);
    step_exp("bits0_1",   72'h3, 72'h3, 8'h0C, 1'b0, 1'b1);
    w = 72'(1) << 71;
    step_exp("bit71",     w, 72'h0, 8'h80, 1'b1, 1'b0);
    w = (72'(1) << 71) | (72'(1) << 70);
    step_exp("bits71_70", w, w, 8'hC0, 1'b0, 1'b1);
    w = (72'(1) << 71) | 72'(1);
    step_exp("bits71_0",  w, w, 8'h87, 1'b0, 1'b1);

    // Back-to-back single-bit sweep over every position of one valid codeword.
    base = valid_word({32'($urandom), 32'($urandom)});
    step_exp("valid_base", base, base, 8'h00, 1'b0, 1'b0);
    for (int k = 0; k < 72; k++) begin
      w = base ^ (72'(1) << k);
      step_exp($sformatf("sweep%0d", k), w, base, syndrome_of(w), 1'b1, 1'b0);
    end

    // Random valid words with 0..3 flipped bits, plus fully random words.
    for (int i = 0; i < 60; i++) begin
      w = valid_word({32'($urandom), 32'($urandom)});
      for (int f = 0; f < int'($urandom_range(3, 0)); f++) w[$urandom_range(71, 0)] ^= 1'b1;
      if (i % 5 == 4) w = rnd72();
      step_ref($sformatf("rand%0d", i), w);
    end

    // Reset asserted mid-stream clears outputs immediately and drops the in-flight word.
    @(negedge clk);
    IN = base ^ 72'h3;
    @(posedge clk);
    #2;
    rst = 1'b1;
    IN  = base ^ 72'h1;
    #1;
`ifdef ECC_STATS_EN
    exp_sgl_cnt = 0;
    exp_dbl_cnt = 0;
`endif
    check_all("midreset", 72'h0, 8'h00, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_all("midreset_hold", 72'h0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    step_ref("after_reset", base ^ (72'(1) << 40));
    step_ref("after_reset2", base);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, mism_count);
    $finish;
  end

endmodule
